// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the decoder arbiter.
// master = arbiter side, slave = requester side.
interface decoder_rr_arbiter_if;
    logic [7:0] REQ;
    logic       EN;
    logic [2:0] I;
    logic [7:0] D;
    logic       TIMEOUT;

    modport master (input REQ, output EN, I, D, TIMEOUT);
    modport slave  (output REQ, input EN, I, D, TIMEOUT);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter that owns the 3-to-8 decoder's EN/I inputs and mirrors its one-hot output on D.
// Optional hold-limit revocation is enabled by defining ARB_HOLD_TIMEOUT_EN.
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int HOLD_W   = 5
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    decoder_rr_arbiter_if.master    bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > (2 ** HOLD_W) - 1) begin : g_badHoldParams
        $error("decoder_rr_arbiter: HOLD_MAX must lie in 2..2**HOLD_W-1");
    end

    state_t      r_state, w_nextState;
    logic        r_en, w_nextEn;
    logic [2:0]  r_idx, w_nextIdx;
    logic [2:0]  r_ptr, w_nextPtr;
    logic [7:0]  r_d, w_nextD;
    logic        r_timeout, w_nextTimeout;
    logic [2:0]  w_win;
    logic        w_ownerReq;
    logic        w_release;

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0] r_cnt, w_nextCnt;
    logic              w_holdHit;

    assign w_holdHit = (r_cnt == HOLD_W'(HOLD_MAX - 1));
    assign w_release = !w_ownerReq || w_holdHit;
`else
    assign w_release = !w_ownerReq;
`endif

    assign w_ownerReq = bus.REQ[r_idx];

    // Scan downward so the request closest above PTR is the last (winning) assignment.
    always_comb begin
        w_win = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (bus.REQ[3'(r_ptr + 3'(k))]) begin
                w_win = 3'(r_ptr + 3'(k));
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextEn      = r_en;
        w_nextIdx     = r_idx;
        w_nextD       = r_d;
        w_nextPtr     = r_ptr;
        w_nextTimeout = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        w_nextCnt     = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (|bus.REQ) begin
                    w_nextState = GRANT;
                    w_nextEn    = 1'b1;
                    w_nextIdx   = w_win;
                    w_nextD     = 8'(1) << w_win;
                    w_nextPtr   = w_win + 3'd1;
`ifdef ARB_HOLD_TIMEOUT_EN
                    w_nextCnt   = '0;
`endif
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_nextState = IDLE;
                    w_nextEn    = 1'b0;
                    w_nextD     = 8'h00;
`ifdef ARB_HOLD_TIMEOUT_EN
                    w_nextCnt     = '0;
                    w_nextTimeout = w_holdHit && w_ownerReq;
`endif
                end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
                    w_nextCnt = r_cnt + HOLD_W'(1);
`endif
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_idx     <= 3'd0;
            r_d       <= 8'h00;
            r_ptr     <= 3'd0;
            r_timeout <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_state   <= w_nextState;
            r_en      <= w_nextEn;
            r_idx     <= w_nextIdx;
            r_d       <= w_nextD;
            r_ptr     <= w_nextPtr;
            r_timeout <= w_nextTimeout;
`ifdef ARB_HOLD_TIMEOUT_EN
            r_cnt     <= w_nextCnt;
`endif
        end
    end

    assign bus.EN      = r_en;
    assign bus.I       = r_idx;
    assign bus.D       = r_d;
    assign bus.TIMEOUT = r_timeout;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: directed vector table, hand sequences and a randomized run
// against an abstract ownership model.
module tb_decoder_rr_arbiter;

    localparam int HoldMax = 16;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;
    int   numChecks = 0;
    int   numFails  = 0;

    decoder_rr_arbiter_if bus();

    decoder_rr_arbiter #(.HOLD_MAX(HoldMax), .HOLD_W(5)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic [2:0] i;
        logic [7:0] d;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    // Abstract model: who owns the decoder, for how many cycles, and where the search starts next.
    int mOwner, mPtr, mLast, mHold;
    bit mTo;

    task automatic modelReset();
        mOwner = -1; mPtr = 0; mLast = 0; mHold = 0; mTo = 0;
    endtask

    task automatic modelStep(input logic [7:0] req);
        mTo = 0;
        if (mOwner < 0) begin
            for (int off = 0; off < 8; off++) begin
                int c;
                c = (mPtr + off) % 8;
                if (req[c]) begin
                    mOwner = c; mLast = c; mPtr = (c + 1) % 8; mHold = 1;
                    break;
                end
            end
        end else if (!req[mOwner]) begin
            mOwner = -1;
        end else if (TimeoutOn && mHold >= HoldMax) begin
            mOwner = -1;
            mTo = 1;
        end else begin
            mHold++;
        end
    endtask

    task automatic checkOutput(input string name, input logic expEn, input logic [2:0] expI,
                               input logic [7:0] expD, input logic expTo);
        numChecks++;
        if (bus.EN !== expEn || bus.I !== expI || bus.D !== expD || bus.TIMEOUT !== expTo) begin
            numFails++;
            $display("[TB] FAIL %s: got EN=%b I=%0d D=%h TIMEOUT=%b, expected EN=%b I=%0d D=%h TIMEOUT=%b",
                     name, bus.EN, bus.I, bus.D, bus.TIMEOUT, expEn, expI, expD, expTo);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req);
        bus.REQ = req;
        @(posedge CLK);
        #1;
    endtask

    task automatic resetDut();
        bus.REQ = 8'h00;
        RST_N   = 1'b0;
        #3;
        checkOutput("reset_state", 1'b0, 3'd0, 8'h00, 1'b0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        modelReset();
    endtask

    task automatic addVec(input logic [7:0] req, input logic en, input logic [2:0] i,
                          input logic [7:0] d, input logic to);
        vec_t v;
        v.req = req; v.en = en; v.i = i; v.d = d; v.to = to;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] req;
        logic [7:0] expD;
        logic       expEn;

        bus.REQ = 8'h00;
        RST_N   = 1'b0;

        // Idle, single owner of 4 cycles, then PTR=5 wrap-around and ignored non-owner requests.
        for (int n = 0; n < 5; n++) addVec(8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int n = 0; n < 4; n++) addVec(8'h01, 1'b1, 3'd0, 8'h01, 1'b0);
        addVec(8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        addVec(8'h10, 1'b1, 3'd4, 8'h10, 1'b0);
        addVec(8'h00, 1'b0, 3'd4, 8'h00, 1'b0);
        addVec(8'h09, 1'b1, 3'd0, 8'h01, 1'b0);
        addVec(8'h09, 1'b1, 3'd0, 8'h01, 1'b0);
        addVec(8'h08, 1'b0, 3'd0, 8'h00, 1'b0);
        addVec(8'h08, 1'b1, 3'd3, 8'h08, 1'b0);
        addVec(8'h18, 1'b1, 3'd3, 8'h08, 1'b0);
        addVec(8'h10, 1'b0, 3'd3, 8'h00, 1'b0);
        addVec(8'h10, 1'b1, 3'd4, 8'h10, 1'b0);
        addVec(8'h00, 1'b0, 3'd4, 8'h00, 1'b0);

        resetDut();
        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n].req);
            checkOutput($sformatf("vector_%0d", n), vecs[n].en, vecs[n].i, vecs[n].d, vecs[n].to);
        end

        // All eight requesting: each owner drops two cycles after its grant, order 0..7 then 0.
        resetDut();
        for (int k = 0; k < 9; k++) begin
            int w;
            w = k % 8;
            req = 8'hFF;
            applyStimulus(req);
            checkOutput($sformatf("rr_grant_%0d", k), 1'b1, 3'(w), 8'(1) << w, 1'b0);
            applyStimulus(req);
            checkOutput($sformatf("rr_hold_%0d", k), 1'b1, 3'(w), 8'(1) << w, 1'b0);
            req[w] = 1'b0;
            applyStimulus(req);
            checkOutput($sformatf("rr_gap_%0d", k), 1'b0, 3'(w), 8'h00, 1'b0);
        end

        // Asynchronous reset in the middle of a grant must clear outputs before the next edge.
        resetDut();
        applyStimulus(8'h20);
        checkOutput("pre_async_reset", 1'b1, 3'd5, 8'h20, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_reset_mid_grant", 1'b0, 3'd0, 8'h00, 1'b0);
        #1;
        RST_N = 1'b1;

        // Requester 2 holds its request indefinitely.
        resetDut();
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int n = 0; n < HoldMax; n++) begin
            applyStimulus(8'h04);
            checkOutput($sformatf("hold_cycle_%0d", n), 1'b1, 3'd2, 8'h04, 1'b0);
        end
        applyStimulus(8'h04);
        checkOutput("timeout_pulse", 1'b0, 3'd2, 8'h00, 1'b1);
        applyStimulus(8'h04);
        checkOutput("regrant_after_timeout", 1'b1, 3'd2, 8'h04, 1'b0);
`else
        for (int n = 0; n < 100; n++) begin
            applyStimulus(8'h04);
            checkOutput($sformatf("no_timeout_%0d", n), 1'b1, 3'd2, 8'h04, 1'b0);
        end
`endif

        // Randomized requests with sticky bits so ownerships last long enough to reach the hold limit.
        resetDut();
        req = 8'h00;
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 99) == 0) req = 8'h00;
            modelStep(req);
            applyStimulus(req);
            expEn = (mOwner >= 0);
            expD  = expEn ? (8'(1) << mLast) : 8'h00;
            checkOutput($sformatf("random_%0d", n), expEn, 3'(mLast), expD, mTo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
